ebus_arb: RTL and testbench

- Arbiter and transfer sequencer for the shared EBUS.
- Grants the bus to one of NREQ requesters (front-end sim, PI function cycles, diagnostics) in round-robin order.
- Drives the controller select and data lines, and runs the demand/xfer handshake with the addressed device.
- Returns read data and completion or timeout status to the winning requester. Sits between the requesters and the EBUS data mux at the top level.

---
 rtl/kl_ebus_pkg.sv | 19 +
 rtl/ebus_rr_pick.sv | 24 ++
 rtl/ebus_arb.sv | 155 +++++++++++++++
 tb/tb_ebus_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kl_ebus_pkg.sv
// Shared EBUS types and constants for the arbiter and its helpers.
package kl_ebus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DEMAND,
    RELEASE,
    ABORT
  } tEbusArbState;

  typedef logic [0:6]  tEbusCS;
  typedef logic [0:35] tEbusWord;

  localparam int unsigned EBUS_TIMEOUT_DEF = 64;
  localparam int unsigned EBUS_CS_W        = 7;
  localparam int unsigned EBUS_WORD_W      = 36;

endpackage

// File: rtl/ebus_rr_pick.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping modulo NREQ.
module ebus_rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[PW'((32'(i_ptr) + k) % NREQ)]) begin
        o_any = 1'b1;
        o_idx = PW'((32'(i_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/ebus_arb.sv
// EBUS arbiter and transfer sequencer: round-robin grant, setup, demand/xfer
// handshake, release and timeout abort, with fully registered outputs.
module ebus_arb
  import kl_ebus_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned TIMEOUT   = EBUS_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          crobar,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_wr,
  input  logic [NREQ*EBUS_CS_W-1:0]     req_cs,
  input  logic [NREQ*EBUS_WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]               grant,
  output logic [NREQ-1:0]               done,
  output logic [NREQ-1:0]               tmo,
  output tEbusWord                      rdata,
  output tEbusCS                        ebus_cs,
  output logic                          ebus_demand,
  input  logic                          ebus_xfer,
  input  tEbusWord                      ebus_din,
  output logic                          drv_en,
  output tEbusWord                      drv_data
);

  localparam int unsigned PW         = $clog2(NREQ);
  localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [9:0]  TO_LAST    = 10'(TIMEOUT - 1);

  tEbusArbState    r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_tmo;
  logic            r_wr;
  tEbusCS          r_cs;
  tEbusWord        r_drv_data;
  tEbusWord        r_rdata;
  logic            r_drv_en;
  logic            r_demand;
  logic [3:0]      r_setup_cnt;
  logic [9:0]      r_to_cnt;

  logic [PW-1:0]   w_idx;
  logic            w_any;

  ebus_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk or posedge crobar) begin
    if (crobar) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_tmo       <= '0;
      r_wr        <= 1'b0;
      r_cs        <= '0;
      r_drv_data  <= '0;
      r_rdata     <= '0;
      r_drv_en    <= 1'b0;
      r_demand    <= 1'b0;
      r_setup_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_done <= '0;
      r_tmo  <= '0;
      case (r_state)
        IDLE: begin
          // No arbitration while done is pulsing: the finished owner still
          // holds req until it has seen done.
          if (w_any && (r_done == '0)) begin
            r_grant     <= NREQ'(1) << w_idx;
            r_ptr       <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            r_wr        <= req_wr[w_idx];
            r_cs        <= req_cs[32'(w_idx) * EBUS_CS_W +: EBUS_CS_W];
            r_drv_en    <= req_wr[w_idx];
            r_drv_data  <= req_wr[w_idx] ?
                           req_data[32'(w_idx) * EBUS_WORD_W +: EBUS_WORD_W] : '0;
            r_setup_cnt <= SETUP_LAST;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (r_setup_cnt == '0) begin
            r_demand <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= DEMAND;
          end else begin
            r_setup_cnt <= r_setup_cnt - 1'b1;
          end
        end
        DEMAND: begin
          if (ebus_xfer) begin
            if (!r_wr) begin
              r_rdata <= ebus_din;
            end
            r_demand   <= 1'b0;
            r_drv_en   <= 1'b0;
            r_drv_data <= '0;
            r_to_cnt   <= '0;
            r_state    <= RELEASE;
          end else if (r_to_cnt == TO_LAST) begin
            r_demand   <= 1'b0;
            r_drv_en   <= 1'b0;
            r_drv_data <= '0;
            r_cs       <= '0;
            r_tmo      <= r_grant;
            r_state    <= ABORT;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!ebus_xfer) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_cs    <= '0;
            r_state <= IDLE;
          end else if (r_to_cnt == TO_LAST) begin
            r_cs    <= '0;
            r_tmo   <= r_grant;
            r_state <= ABORT;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ABORT: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign tmo         = r_tmo;
  assign rdata       = r_rdata;
  assign ebus_cs     = r_cs;
  assign ebus_demand = r_demand;
  assign drv_en      = r_drv_en;
  assign drv_data    = r_drv_data;

endmodule

// File: tb/tb_ebus_arb.sv
// Randomized self-checking bench for ebus_arb with a transaction-level
// round-robin/rdata model and a behavioural EBUS device.
`timescale 1ns/1ps
module tb_ebus_arb;

  localparam int NREQ  = 3;
  localparam int SETUP = 2;
  localparam int TMO   = 64;
  localparam int CW    = NREQ * 7;
  localparam int DW    = NREQ * 36;

  logic            clk = 1'b0;
  logic            crobar;
  logic [NREQ-1:0] req, req_wr, grant, done, tmo;
  logic [CW-1:0]   req_cs;
  logic [DW-1:0]   req_data;
  logic [35:0]     rdata, ebus_din, drv_data;
  logic [6:0]      ebus_cs;
  logic            ebus_demand, ebus_xfer, drv_en;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_ptr    = 0;
  logic [35:0] m_rdata  = '0;

  typedef struct packed {
    int              ticks;
    int              n_setup;
    int              n_demand;
    int              n_release;
    int              n_done;
    int              n_tmo;
    int              hold_bad;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done_v;
    logic [NREQ-1:0] tmo_v;
    logic [6:0]      cs;
    logic            drv_en;
    logic [35:0]     drv_data;
    logic            drv_en_rel;
    logic [6:0]      cs_end;
    logic            dem_end;
    logic            drv_end;
    logic [35:0]     rdata;
    logic            timed_out;
  } obs_t;

  ebus_arb #(
    .NREQ      (NREQ),
    .SETUP_CYC (SETUP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .crobar      (crobar),
    .req         (req),
    .req_wr      (req_wr),
    .req_cs      (req_cs),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .tmo         (tmo),
    .rdata       (rdata),
    .ebus_cs     (ebus_cs),
    .ebus_demand (ebus_demand),
    .ebus_xfer   (ebus_xfer),
    .ebus_din    (ebus_din),
    .drv_en      (drv_en),
    .drv_data    (drv_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [35:0] rand36();
    return {4'($urandom), $urandom};
  endfunction

  task automatic rand_inputs();
    req_wr   = NREQ'($urandom);
    req_cs   = CW'($urandom);
    req_data = DW'({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Device: raises xfer on the after-th demand cycle, drops it hold cycles
  // into release; optional xfer glitch during setup.
  task automatic run_one(input int after, input int hold, input logic [35:0] din, input int budget,
                         input bit keep_req, input bit scramble, input bit glitch, output obs_t o);
    int dcnt;
    int rcnt;
    bit seen_dem;
    dcnt = 0;
    rcnt = 0;
    seen_dem = 0;
    o = '0;
    o.timed_out = 1'b1;
    ebus_xfer = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      o.ticks++;
      if (grant != '0 && o.gnt == '0) begin
        o.gnt = grant; o.cs = ebus_cs; o.drv_en = drv_en; o.drv_data = drv_data;
        if (scramble) rand_inputs();
      end
      if (done != '0 || tmo != '0) begin
        if (done != '0) o.n_done++;
        if (tmo != '0) o.n_tmo++;
        o.done_v = done; o.tmo_v = tmo;
        o.cs_end = ebus_cs; o.dem_end = ebus_demand; o.drv_end = drv_en; o.rdata = rdata;
        if (!keep_req) req = req & ~(done | tmo);
        ebus_xfer = 1'b0;
        o.timed_out = 1'b0;
        break;
      end
      if (ebus_demand) begin
        seen_dem = 1; o.n_demand++; dcnt++;
        if (ebus_cs !== o.cs || drv_en !== o.drv_en || drv_data !== o.drv_data) o.hold_bad++;
        ebus_xfer = (dcnt >= after);
      end else if (grant != '0 && !seen_dem) begin
        o.n_setup++;
        if (ebus_cs !== o.cs || drv_en !== o.drv_en || drv_data !== o.drv_data) o.hold_bad++;
        ebus_xfer = glitch;
      end else if (grant != '0) begin
        o.n_release++;
        o.drv_en_rel |= drv_en;
        if (ebus_cs !== o.cs) o.hold_bad++;
        if (rcnt >= hold) ebus_xfer = 1'b0;
        else rcnt++;
      end
      ebus_din = ebus_xfer ? din : rand36();
    end
  endtask

  task automatic test_reset();
    crobar = 1'b1; req = '0; req_wr = '0; req_cs = '0; req_data = '0;
    ebus_xfer = 1'b0; ebus_din = '0;
    tick();
    n_checks++; if (grant !== '0 || done !== '0 || tmo !== '0) begin n_errors++; $display("FAIL rst_flags grant=%b done=%b tmo=%b want 0", grant, done, tmo); end
    n_checks++; if (ebus_demand !== 1'b0 || drv_en !== 1'b0 || ebus_cs !== '0) begin n_errors++; $display("FAIL rst_bus dem=%b drv=%b cs=%o want 0", ebus_demand, drv_en, ebus_cs); end
    n_checks++; if (drv_data !== '0 || rdata !== '0) begin n_errors++; $display("FAIL rst_data drv=%o rdata=%o want 0", drv_data, rdata); end
    crobar = 1'b0;
    repeat (3) tick();
    n_checks++; if (grant !== '0 || ebus_demand !== 1'b0) begin n_errors++; $display("FAIL idle_noreq grant=%b dem=%b want 0", grant, ebus_demand); end
    m_ptr = 0; m_rdata = '0;
  endtask

  task automatic test_single_read();
    obs_t o;
    logic [35:0] din;
    din = 36'o123456701234;
    req_wr = 3'b000; req_cs = CW'(7'o12) << 7; req = 3'b010;
    run_one(3, 0, din, 40, 0, 0, 0, o);
    m_ptr = 2; m_rdata = din;
    n_checks++; if (o.timed_out) begin n_errors++; $display("FAIL rd_budget ended=0 want 1"); end
    n_checks++; if (o.gnt !== 3'b010) begin n_errors++; $display("FAIL rd_grant got=%b want=010", o.gnt); end
    n_checks++; if (o.cs !== 7'o12) begin n_errors++; $display("FAIL rd_cs got=%o want=12", o.cs); end
    n_checks++; if (o.n_setup != SETUP) begin n_errors++; $display("FAIL rd_setup got=%0d want=%0d", o.n_setup, SETUP); end
    n_checks++; if (o.n_demand != 3) begin n_errors++; $display("FAIL rd_demand got=%0d want=3", o.n_demand); end
    n_checks++; if (o.hold_bad != 0 || o.drv_en !== 1'b0) begin n_errors++; $display("FAIL rd_hold bad=%0d drv=%b want 0/0", o.hold_bad, o.drv_en); end
    n_checks++; if (o.done_v !== 3'b010 || o.n_tmo != 0) begin n_errors++; $display("FAIL rd_done got=%b tmo=%0d want=010/0", o.done_v, o.n_tmo); end
    n_checks++; if (o.rdata !== din) begin n_errors++; $display("FAIL rd_rdata got=%o want=%o", o.rdata, din); end
    n_checks++; if (o.ticks != 1 + SETUP + 3 + 1) begin n_errors++; $display("FAIL rd_latency got=%0d want=%0d", o.ticks, 1 + SETUP + 4); end
  endtask

  task automatic test_single_write();
    obs_t o;
    logic [35:0] wd;
    wd = 36'o777000777000;
    req_wr = 3'b001; req_cs = CW'(7'o55); req_data = DW'(wd); req = 3'b001;
    run_one(2, 1, rand36(), 40, 0, 0, 1, o);
    m_ptr = 1;
    n_checks++; if (o.gnt !== 3'b001 || o.timed_out) begin n_errors++; $display("FAIL wr_grant got=%b to=%b want=001", o.gnt, o.timed_out); end
    n_checks++; if (o.drv_en !== 1'b1 || o.drv_data !== wd) begin n_errors++; $display("FAIL wr_drive en=%b data=%o want 1/%o", o.drv_en, o.drv_data, wd); end
    n_checks++; if (o.hold_bad != 0) begin n_errors++; $display("FAIL wr_stable changes=%0d want 0", o.hold_bad); end
    n_checks++; if (o.drv_en_rel !== 1'b0) begin n_errors++; $display("FAIL wr_release_drv got=%b want 0", o.drv_en_rel); end
    n_checks++; if (o.n_demand != 2 || o.n_release != 2) begin n_errors++; $display("FAIL wr_phases dem=%0d rel=%0d want 2/2", o.n_demand, o.n_release); end
    n_checks++; if (o.done_v !== 3'b001 || o.rdata !== m_rdata) begin n_errors++; $display("FAIL wr_done done=%b rdata=%o want 001/%o", o.done_v, o.rdata, m_rdata); end
  endtask

  task automatic test_fairness();
    obs_t o;
    int exp_order [6];
    logic [35:0] din;
    exp_order = '{0, 1, 2, 0, 1, 2};
    crobar = 1'b1; #2; crobar = 1'b0;
    m_ptr = 0; m_rdata = '0;
    req_wr = '0; req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      din = rand36();
      run_one(1, 0, din, 30, 1, 0, 0, o);
      m_ptr = (pick(req, m_ptr) + 1) % NREQ; m_rdata = din;
      n_checks++; if (o.gnt !== 3'(1 << exp_order[i]) || o.done_v !== o.gnt) begin n_errors++; $display("FAIL rr_order[%0d] grant=%b done=%b want=%b", i, o.gnt, o.done_v, 3'(1 << exp_order[i])); end
      n_checks++; if (o.rdata !== din) begin n_errors++; $display("FAIL rr_rdata[%0d] got=%o want=%o", i, o.rdata, din); end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    obs_t o;
    req_wr = 3'b100; req_cs = CW'(7'o77) << 14; req_data = '1; req = 3'b100;
    run_one(1000, 0, rand36(), 200, 0, 0, 0, o);
    m_ptr = 0;
    n_checks++; if (o.n_demand != TMO) begin n_errors++; $display("FAIL to_demand_len got=%0d want=%0d", o.n_demand, TMO); end
    n_checks++; if (o.tmo_v !== 3'b100 || o.n_tmo != 1 || o.n_done != 0) begin n_errors++; $display("FAIL to_pulse tmo=%b done=%0d want 100/0", o.tmo_v, o.n_done); end
    n_checks++; if (o.dem_end !== 1'b0 || o.drv_end !== 1'b0 || o.cs_end !== '0) begin n_errors++; $display("FAIL to_bus_off dem=%b drv=%b cs=%o want 0", o.dem_end, o.drv_end, o.cs_end); end
    n_checks++; if (o.rdata !== m_rdata) begin n_errors++; $display("FAIL to_rdata got=%o want=%o", o.rdata, m_rdata); end
    tick(); tick();
    n_checks++; if (done !== '0 || tmo !== '0 || grant !== '0) begin n_errors++; $display("FAIL to_after done=%b tmo=%b grant=%b want 0", done, tmo, grant); end
  endtask

  task automatic test_boundary();
    obs_t o;
    logic [35:0] din;
    din = rand36();
    req_wr = 3'b000; req = 3'b010;
    run_one(TMO, 0, din, 200, 0, 0, 0, o);
    m_ptr = 2; m_rdata = din;
    n_checks++; if (o.done_v !== 3'b010 || o.n_tmo != 0) begin n_errors++; $display("FAIL bnd_xfer_wins done=%b tmo=%0d want 010/0", o.done_v, o.n_tmo); end
    n_checks++; if (o.n_demand != TMO || o.rdata !== din) begin n_errors++; $display("FAIL bnd_data dem=%0d rdata=%o want %0d/%o", o.n_demand, o.rdata, TMO, din); end
    din = rand36();
    req_wr = 3'b000; req = 3'b001;
    run_one(1, 100000, din, 300, 0, 0, 0, o);
    m_ptr = 1; m_rdata = din;
    n_checks++; if (o.tmo_v !== 3'b001 || o.n_done != 0) begin n_errors++; $display("FAIL stuck_tmo tmo=%b done=%0d want 001/0", o.tmo_v, o.n_done); end
    n_checks++; if (o.n_release != TMO) begin n_errors++; $display("FAIL stuck_len got=%0d want=%0d", o.n_release, TMO); end
    n_checks++; if (o.rdata !== din) begin n_errors++; $display("FAIL stuck_rdata got=%o want=%o", o.rdata, din); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int r = 0; r < 30; r++) begin
      int w, after, hold;
      logic [6:0] cs_e;
      logic we;
      logic [35:0] wd, din;
      req = req | NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rand_inputs();
      w = pick(req, m_ptr);
      cs_e = req_cs[w*7 +: 7]; we = req_wr[w]; wd = we ? req_data[w*36 +: 36] : '0;
      after = $urandom_range(1, 6); hold = $urandom_range(0, 3); din = rand36();
      run_one(after, hold, din, 60, 0, 1, (r % 2 == 1), o);
      m_ptr = (w + 1) % NREQ;
      if (!we) m_rdata = din;
      n_checks++; if (o.gnt !== 3'(1 << w) || o.timed_out) begin n_errors++; $display("FAIL rnd_grant[%0d] got=%b want=%b", r, o.gnt, 3'(1 << w)); end
      n_checks++; if (o.cs !== cs_e || o.drv_en !== we || o.drv_data !== wd) begin n_errors++; $display("FAIL rnd_latch[%0d] cs=%o en=%b d=%o want %o/%b/%o", r, o.cs, o.drv_en, o.drv_data, cs_e, we, wd); end
      n_checks++; if (o.n_setup != SETUP || o.n_demand != after || o.n_release != hold + 1) begin n_errors++; $display("FAIL rnd_phases[%0d] s=%0d d=%0d r=%0d want %0d/%0d/%0d", r, o.n_setup, o.n_demand, o.n_release, SETUP, after, hold + 1); end
      n_checks++; if (o.hold_bad != 0 || o.drv_en_rel !== 1'b0) begin n_errors++; $display("FAIL rnd_stable[%0d] bad=%0d reldrv=%b want 0/0", r, o.hold_bad, o.drv_en_rel); end
      n_checks++; if (o.done_v !== 3'(1 << w) || o.n_tmo != 0) begin n_errors++; $display("FAIL rnd_done[%0d] got=%b tmo=%0d want=%b/0", r, o.done_v, o.n_tmo, 3'(1 << w)); end
      n_checks++; if (o.rdata !== m_rdata) begin n_errors++; $display("FAIL rnd_rdata[%0d] got=%o want=%o", r, o.rdata, m_rdata); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [35:0] din;
    req_wr = 3'b001; req_data = '1; req_cs = '1; req = 3'b001;
    for (int c = 0; c < 20 && !ebus_demand; c++) tick();
    n_checks++; if (ebus_demand !== 1'b1) begin n_errors++; $display("FAIL rmid_reach_demand got=%b want=1", ebus_demand); end
    #2 crobar = 1'b1;
    #1;
    n_checks++; if (ebus_demand !== 1'b0 || drv_en !== 1'b0 || grant !== '0 || ebus_cs !== '0) begin n_errors++; $display("FAIL rmid_async dem=%b drv=%b grant=%b cs=%o want 0", ebus_demand, drv_en, grant, ebus_cs); end
    tick();
    n_checks++; if (done !== '0 || tmo !== '0) begin n_errors++; $display("FAIL rmid_no_status done=%b tmo=%b want 0", done, tmo); end
    crobar = 1'b0;
    m_ptr = 0; m_rdata = '0;
    din = rand36();
    req_wr = '0; req = 3'b111;
    run_one(1, 0, din, 30, 0, 0, 0, o);
    n_checks++; if (o.gnt !== 3'b001 || o.done_v !== 3'b001) begin n_errors++; $display("FAIL rmid_first_grant got=%b done=%b want=001", o.gnt, o.done_v); end
    n_checks++; if (o.rdata !== din) begin n_errors++; $display("FAIL rmid_rdata got=%o want=%o", o.rdata, din); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_fairness();
    test_timeout();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
